// File: rtl/row_window_ctrl.sv
// -----------------------------------------------------------------------------
// row_window_ctrl
//
// Sequencer for the 16-pixel register FIFO (reg_fifo_16) of the input layer.
// Fetches 128-bit line-RAM words (8 x 16-bit pixels) into the FIFO, presents
// 3-pixel windows downstream under valid/ready, and walks a configured number
// of rows per frame. The FIFO gets Start, one_row_complete and stride control.
//
// Optional feature macro: ROW_WINDOW_CTRL_STALL_CNT_EN
//   defined   -> stall_cycles counts RUN cycles that were waiting on FIFO data
//   undefined -> stall_cycles is tied to zero
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle pulse, latches cfg_* and (re)starts a frame
//   cfg_base_addr       first RAM word of the frame
//   cfg_words_per_row   RAM words fetched per row (>= 1)
//   cfg_win_per_row     windows popped per row (>= 1)
//   cfg_rows            rows per frame (>= 1)
//   cfg_stride2         1 = stride 2
//   rd_en, rd_addr      RAM read port (data valid one cycle after rd_en)
//   fifo_push/pop       FIFO push (RAM data) / pop (one window consumed)
//   fifo_start          FIFO Start pulse
//   fifo_row_done       FIFO one_row_complete pulse
//   fifo_stride2en      latched cfg_stride2
//   fifo_count          FIFO occupancy
//   window_valid/ready  downstream window handshake
//   busy, done          frame in progress / one-cycle end-of-frame pulse
//   stall_cycles        data-starved RUN cycle counter (optional feature)
// -----------------------------------------------------------------------------
module row_window_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int WIN_W    = 10,
    parameter int WORD_W   = 6,
    parameter int PUSH_MAX = 7,
    parameter int POP_MIN  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [WORD_W-1:0] cfg_words_per_row,
    input  logic [WIN_W-1:0]  cfg_win_per_row,
    input  logic [WIN_W-1:0]  cfg_rows,
    input  logic              cfg_stride2,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              fifo_push,
    output logic              fifo_pop,
    output logic              fifo_start,
    output logic              fifo_row_done,
    output logic              fifo_stride2en,
    input  logic [3:0]        fifo_count,
    output logic              window_valid,
    input  logic              window_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RUN     = 3'd2,
        ROW_END = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [3:0] PUSH_MAX_C = 4'(PUSH_MAX);
    localparam logic [3:0] POP_MIN_C  = 4'(POP_MIN);

    state_t            state_r;
    logic [WORD_W-1:0] words_cfg_r;
    logic [WIN_W-1:0]  win_cfg_r;
    logic [WIN_W-1:0]  rows_cfg_r;
    logic              stride2_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [WORD_W-1:0] words_issued_r;
    logic [WIN_W-1:0]  win_done_r;
    logic [WIN_W-1:0]  row_r;
    logic              inflight_r;
    logic              cool_r;
    logic              fifo_start_r;
    logic              row_done_r;
    logic              done_r;
    logic              busy_r;

    logic              run_s;
    logic              win_left_s;
    logic              window_valid_s;
    logic              pop_s;
    logic              rd_en_s;
    logic              last_pop_s;
    logic [WIN_W-1:0]  row_next_s;

    // Fetch / pop qualification; start masks all activity in its own cycle.
    always_comb begin
        run_s          = 1'b0;
        win_left_s     = 1'b0;
        window_valid_s = 1'b0;
        pop_s          = 1'b0;
        rd_en_s        = 1'b0;
        last_pop_s     = 1'b0;
        row_next_s     = row_r + WIN_W'(1);
        if ((state_r == RUN) && !start) begin
            run_s = 1'b1;
        end else begin
            run_s = 1'b0;
        end
        if (win_done_r < win_cfg_r) begin
            win_left_s = 1'b1;
        end else begin
            win_left_s = 1'b0;
        end
        if (run_s && (fifo_count >= POP_MIN_C) && win_left_s) begin
            window_valid_s = 1'b1;
        end else begin
            window_valid_s = 1'b0;
        end
        pop_s = window_valid_s & window_ready;
        // cool_r keeps one idle cycle after a push so fifo_count has caught up
        // before the next read decision.
        if (run_s && (words_issued_r < words_cfg_r) && !inflight_r && !cool_r
                && (fifo_count <= PUSH_MAX_C)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
        if (pop_s && ((win_done_r + WIN_W'(1)) == win_cfg_r)) begin
            last_pop_s = 1'b1;
        end else begin
            last_pop_s = 1'b0;
        end
    end

    // Frame FSM, counters, address generation and registered control pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            words_cfg_r    <= '0;
            win_cfg_r      <= '0;
            rows_cfg_r     <= '0;
            stride2_r      <= 1'b0;
            rd_addr_r      <= '0;
            words_issued_r <= '0;
            win_done_r     <= '0;
            row_r          <= '0;
            inflight_r     <= 1'b0;
            cool_r         <= 1'b0;
            fifo_start_r   <= 1'b0;
            row_done_r     <= 1'b0;
            done_r         <= 1'b0;
            busy_r         <= 1'b0;
        end else if (start) begin
            state_r        <= INIT;
            words_cfg_r    <= cfg_words_per_row;
            win_cfg_r      <= cfg_win_per_row;
            rows_cfg_r     <= cfg_rows;
            stride2_r      <= cfg_stride2;
            rd_addr_r      <= cfg_base_addr;
            words_issued_r <= '0;
            win_done_r     <= '0;
            row_r          <= '0;
            inflight_r     <= 1'b0;
            cool_r         <= 1'b0;
            fifo_start_r   <= 1'b1;
            row_done_r     <= 1'b0;
            done_r         <= 1'b0;
            busy_r         <= 1'b1;
        end else begin
            fifo_start_r <= 1'b0;
            row_done_r   <= 1'b0;
            done_r       <= 1'b0;
            inflight_r   <= rd_en_s;
            cool_r       <= inflight_r;
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                end
                INIT: begin
                    state_r <= RUN;
                end
                RUN: begin
                    if (rd_en_s) begin
                        rd_addr_r      <= rd_addr_r + ADDR_W'(1);
                        words_issued_r <= words_issued_r + WORD_W'(1);
                    end
                    if (pop_s) begin
                        win_done_r <= win_done_r + WIN_W'(1);
                    end
                    if (last_pop_s) begin
                        state_r    <= ROW_END;
                        row_done_r <= 1'b1;
                    end
                end
                ROW_END: begin
                    // rd_addr is not re-based: rows are contiguous in RAM.
                    row_r          <= row_next_s;
                    words_issued_r <= '0;
                    win_done_r     <= '0;
                    if (row_next_s == rows_cfg_r) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROW_WINDOW_CTRL_STALL_CNT_EN
    logic [15:0] stall_r;

    // Saturating count of RUN cycles spent waiting for FIFO data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_r <= 16'd0;
        end else if (start) begin
            stall_r <= 16'd0;
        end else if ((state_r == RUN) && !window_valid_s && win_left_s
                     && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign stall_cycles = stall_r;
`else
    assign stall_cycles = 16'd0;
`endif

    assign rd_en          = rd_en_s;
    assign rd_addr        = rd_addr_r;
    // A read whose data lands in the same cycle as start is dropped.
    assign fifo_push      = inflight_r & ~start;
    assign fifo_pop       = pop_s;
    assign fifo_start     = fifo_start_r;
    assign fifo_row_done  = row_done_r;
    assign fifo_stride2en = stride2_r;
    assign window_valid   = window_valid_s;
    assign busy           = busy_r;
    assign done           = done_r;

endmodule

// File: doc/row_window_ctrl.md
Name: row_window_ctrl

Overview:
- Sequencer for the 16-pixel register FIFO (`reg_fifo_16`) in the input layer.
- Fetches 128-bit words (8 × 16-bit pixels) from the line block RAM and pushes them into the FIFO.
- Pops 3-pixel windows to the downstream 3x3 window builder under a valid/ready handshake.
- Issues per-row `one_row_complete`, frame `Start` and stride control to the FIFO, and walks a configured number of rows per frame.

Parameters:
- ADDR_W, 8, block RAM word address width
- WIN_W, 10, width of windows-per-row and row counters
- WORD_W, 6, width of words-per-row counter
- PUSH_MAX, 7, FIFO accepts push only while fifo_count <= PUSH_MAX
- POP_MIN, 3, FIFO pops only while fifo_count >= POP_MIN

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg_*, (re)starts frame from any state
- cfg_base_addr  in  ADDR_W  first RAM word of frame
- cfg_words_per_row  in  WORD_W  RAM words per row (>=1)
- cfg_win_per_row  in  WIN_W  windows popped per row (>=1)
- cfg_rows  in  WIN_W  rows per frame (>=1)
- cfg_stride2  in  1  1 = stride 2
- rd_en  out  1  RAM read enable
- rd_addr  out  ADDR_W  RAM read address; data valid 1 cycle after rd_en
- fifo_push  out  1  push RAM output into FIFO
- fifo_pop  out  1  pop FIFO (one window consumed)
- fifo_start  out  1  FIFO Start
- fifo_row_done  out  1  FIFO one_row_complete
- fifo_stride2en  out  1  latched cfg_stride2
- fifo_count  in  4  FIFO occupancy
- window_valid  out  1  FIFO head window is valid for the current row
- window_ready  in  1  downstream accepts
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last row
- stall_cycles  out  16  see Optional Feature

Behaviour:
- Reset values:
  - All outputs 0; rd_addr = 0; state IDLE.
  - Internal counters and the inflight flag are 0.
- States and transitions:
  - IDLE
  - INIT: fifo_start = 1 for exactly 1 cycle.
  - RUN
  - ROW_END: fifo_row_done = 1 for exactly 1 cycle.
  - DONE: done = 1 for 1 cycle, then IDLE.
- start, sampled in any state:
  - Latches cfg_*, rd_addr <= cfg_base_addr.
  - Clears word, window and row counters and the inflight flag; next state INIT.
  - start has priority over all other events.
- Fetch (RUN only):
  - rd_en = 1 when words_issued < cfg_words_per_row, inflight = 0, fifo_push = 0 this cycle, and fifo_count <= PUSH_MAX.
  - On rd_en: rd_addr increments on the following cycle (mod 2^ADDR_W); inflight <= 1; words_issued++.
  - The cycle after rd_en: fifo_push = 1, inflight <= 0. At most one word in flight.
  - The next read may issue no earlier than 2 cycles after push, so fifo_count has updated.
- Pop (RUN only):
  - window_valid = fifo_count >= POP_MIN && win_done < cfg_win_per_row.
  - fifo_pop = window_valid & window_ready; win_done++ on pop.
  - Push and pop in the same cycle are allowed.
- Row end:
  - Pop making win_done == cfg_win_per_row → ROW_END.
  - In ROW_END: row++, words_issued/win_done cleared; rd_addr keeps incrementing across rows (no re-basing).
  - If row == cfg_rows → DONE, else RUN.
- fifo_stride2en is held from latch until the next start.
- Windows are never presented outside RUN. window_valid is 0 in INIT/ROW_END/DONE/IDLE regardless of fifo_count.
- Reset mid-frame: immediate return to IDLE and reset values; an in-flight read is dropped (no push).
- Starvation: if all words are issued and fifo_count < POP_MIN with windows remaining, the block waits in RUN (config error; no recovery besides start/reset).

Optional Feature:
- Macro ROW_WINDOW_CTRL_STALL_CNT_EN.
- Defined:
  - stall_cycles counts RUN cycles with window_valid = 0 and win_done < cfg_win_per_row.
  - Saturates at 16'hFFFF; cleared on start.
- Undefined: stall_cycles tied to 0; no counter logic.

Test Plan:
- Single row, stride1: base=0x10, words=2, win=14, rows=1, ready=1.
  - Exactly 2 rd_en at addr 0x10, 0x11; fifo_push each one cycle after its rd_en.
  - 14 fifo_pop; one fifo_row_done pulse; done pulse; busy falls.
- Two rows, stride2: words=2, win=7, rows=2.
  - fifo_stride2en = 1 throughout; addresses 0x10..0x13 contiguous.
  - 7 pops per row; 2 fifo_row_done pulses, 1 done.
- Backpressure: window_ready toggled 1/0 every cycle, 14-window row.
  - No pop while ready = 0; window_valid stays high while fifo_count >= 3.
  - Total pops = 14; reads never issue with fifo_count > 7.
- Address wrap: base=0xFF, words=2.
  - rd_addr sequence 0xFF, 0x00.
- Restart: start asserted mid-row with inflight = 1.
  - No fifo_push from the dropped read; fifo_start pulse next cycle; fetch resumes at the new cfg_base_addr.
- Async reset asserted mid-RUN.
  - All outputs 0 without a clock edge; after release, idle until start.
  - With ROW_WINDOW_CTRL_STALL_CNT_EN, stall_cycles = 0.
